// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and holds each
// word for the decoder until execute retires it, then steers to the sequential/beq/j target.
module fetch_unit #(
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic                  retire,
    input  logic                  beq_inst,
    input  logic                  zero,
    input  logic                  j_inst
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StValid
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;

    logic                    load_inst;
    logic                    take_retire;
    logic [ADDR_WIDTH-1:0]   seq_pc;
    logic [ADDR_WIDTH-1:0]   jump_target;
    logic [ADDR_WIDTH-1:0]   branch_offset;
    logic [ADDR_WIDTH-1:0]   branch_target;
    logic [ADDR_WIDTH-1:0]   next_pc;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (imem_ack) state_d = StValid;
            StValid: if (retire) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StFetch: imem_req = 1'b1;
            StValid: inst_valid = 1'b1;
            default: ;
        endcase
    end

    assign load_inst   = (state_q == StFetch) && imem_ack;
    assign take_retire = (state_q == StValid) && retire;

    // Target computation assumes MIPS field layout: ADDR_WIDTH >= 29, INST_WIDTH >= 26.
    assign seq_pc        = pc_q + ADDR_WIDTH'(4);
    assign jump_target   = {seq_pc[ADDR_WIDTH-1:28], inst_q[25:0], 2'b00};
    assign branch_offset = {{(ADDR_WIDTH-18){inst_q[15]}}, inst_q[15:0], 2'b00};
    assign branch_target = seq_pc + branch_offset;

    always_comb begin
        next_pc = seq_pc;
        if (j_inst) begin
            next_pc = jump_target;
        end else if (beq_inst && zero) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        if (load_inst) begin
            inst_d = imem_rdata;
        end
        if (take_retire) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = seq_pc;
    assign inst      = inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (different reset PCs) share stimulus and
// are compared every cycle against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_LO = 32'h0000_0000;
    localparam logic [31:0] RST_HI = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        retire;
    logic        beq_inst;
    logic        zero;
    logic        j_inst;

    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4;
    logic        req_hi, valid_hi;
    logic [31:0] addr_hi, inst_hi, pc_hi, pc_plus4_hi;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: observable outputs and the two PCs
    bit          m_req   = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = RST_LO;
    logic [31:0] m_pc_hi = RST_HI;

    fetch_unit #(.INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_LO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4), .retire(retire),
        .beq_inst(beq_inst), .zero(zero), .j_inst(j_inst)
    );

    fetch_unit #(.INST_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RST_HI)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_hi), .imem_addr(addr_hi), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst_hi), .inst_valid(valid_hi),
        .pc(pc_hi), .pc_plus4(pc_plus4_hi), .retire(retire),
        .beq_inst(beq_inst), .zero(zero), .j_inst(j_inst)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] w,
                                                input bit b, input bit z, input bit j);
        longint seq;
        longint r;
        int     off;
        seq = (longint'(cur) + 4) & 64'hFFFF_FFFF;
        if (j) begin
            r = (seq & 64'hF000_0000) + (longint'(w & 32'h03FF_FFFF) * 4);
        end else if (b && z) begin
            off = int'($signed(w[15:0]));
            r   = seq + longint'(off) * 4;
        end else begin
            r = seq;
        end
        return r[31:0];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_req   <= 1'b0;
            m_valid <= 1'b0;
            m_inst  <= '0;
            m_pc    <= RST_LO;
            m_pc_hi <= RST_HI;
        end else if (m_req) begin
            if (imem_ack) begin
                m_inst  <= imem_rdata;
                m_req   <= 1'b0;
                m_valid <= 1'b1;
            end
        end else if (m_valid) begin
            if (retire) begin
                m_pc    <= ref_next_pc(m_pc, m_inst, beq_inst, zero, j_inst);
                m_pc_hi <= ref_next_pc(m_pc_hi, m_inst, beq_inst, zero, j_inst);
                m_valid <= 1'b0;
                m_req   <= 1'b1;
            end
        end else begin
            m_req <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("imem_req", 32'(imem_req), 32'(m_req));
            check_eq("inst_valid", 32'(inst_valid), 32'(m_valid));
            check_eq("inst", inst, m_inst);
            check_eq("pc", pc, m_pc);
            check_eq("imem_addr", imem_addr, m_pc);
            check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
            check_eq("hi_req", 32'(req_hi), 32'(m_req));
            check_eq("hi_valid", 32'(valid_hi), 32'(m_valid));
            check_eq("hi_inst", inst_hi, m_inst);
            check_eq("hi_pc", pc_hi, m_pc_hi);
            check_eq("hi_addr", addr_hi, m_pc_hi);
            check_eq("hi_pc_plus4", pc_plus4_hi, m_pc_hi + 32'd4);
        end
    end

    // Holds reset for 'cycles' edges; ack_hi keeps ack asserted through reset and the idle cycle.
    task automatic do_reset(input int cycles, input bit ack_hi);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            imem_ack   = ack_hi ? 1'b1 : 1'($urandom);
            retire     = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(inst_valid), 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_pc", pc, RST_LO);
        check_eq("rst_pc_hi", pc_hi, RST_HI);
        rst_n    = 1'b1;
        imem_ack = ack_hi;
        retire   = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check_eq("post_rst_req", 32'(imem_req), 32'h1);
        check_eq("post_rst_addr", imem_addr, RST_LO);
    endtask

    // Entered with the DUT in FETCH; returns with the DUT back in FETCH at the next PC.
    task automatic run_inst(input int waits, input logic [31:0] word, input int rdelay,
                            input bit b, input bit z, input bit j, input bit hold_retire,
                            input logic [31:0] exp_addr);
        int rd;
        rd = hold_retire ? 0 : rdelay;
        for (int i = 0; i < waits; i++) begin
            check_eq("fetch_addr", imem_addr, exp_addr);
            check_eq("fetch_novalid", 32'(inst_valid), 32'h0);
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            retire     = hold_retire ? 1'b1 : 1'($urandom);
            beq_inst   = 1'($urandom);
            zero       = 1'($urandom);
            j_inst     = 1'($urandom);
            @(negedge clk);
        end
        check_eq("fetch_addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        retire     = hold_retire ? 1'b1 : 1'($urandom);
        @(negedge clk);
        check_eq("ack_valid", 32'(inst_valid), 32'h1);
        check_eq("ack_inst", inst, word);
        for (int d = 0; d < rd; d++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            retire     = 1'b0;
            beq_inst   = 1'($urandom);
            zero       = 1'($urandom);
            j_inst     = 1'($urandom);
            @(negedge clk);
        end
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        retire     = 1'b1;
        beq_inst   = b;
        zero       = z;
        j_inst     = j;
        @(negedge clk);
        imem_ack = 1'b0;
        retire   = 1'b0;
        check_eq("retire_drop", 32'(inst_valid), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        retire     = 1'b0;
        beq_inst   = 1'b0;
        zero       = 1'b0;
        j_inst     = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        do_reset(3, 1'b0);

        // Sequential, zero-wait, retire on each valid cycle
        run_inst(0, 32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_inst(0, 32'h2009_0003, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
        check_eq("seq_addr", imem_addr, 32'h8);

        // 3-wait memory with retire held high throughout
        run_inst(3, 32'h012A_4020, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8);
        check_eq("wait_next_pc", pc, 32'hC);
        run_inst(1, 32'h0000_0020, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC);

        // Branches from pc=0x10
        run_inst(1, 32'h1109_FFFC, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        check_eq("beq_taken", pc, 32'h4);
        run_inst(0, 32'h1109_0002, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4);
        check_eq("beq_fwd", pc, 32'h10);
        run_inst(2, 32'h1109_FFFC, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
        check_eq("beq_not_taken", pc, 32'h14);

        // Reset mid-FETCH with ack arriving during reset and in IDLE
        imem_ack = 1'b0;
        @(negedge clk);
        do_reset(2, 1'b1);

        // Jump with beq also flagged; hi instance starts at 0x4000_0020
        run_inst(0, 32'h0800_0100, 0, 1'b1, 1'b1, 1'b1, 1'b0, RST_LO);
        check_eq("jump_hi", pc_hi, 32'h4000_0400);
        check_eq("jump_lo", pc, 32'h0000_0400);

        // PC wrap
        run_inst(0, 32'h1000_FEFE, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
        check_eq("wrap_setup", pc, 32'hFFFF_FFFC);
        run_inst(1, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        check_eq("wrap_pc", pc, 32'h0);

        // Randomized traffic with occasional resets mid-FETCH and mid-VALID
        for (int n = 0; n < 300; n++) begin
            int mode;
            mode = int'($urandom_range(0, 19));
            if (mode == 0) begin
                do_reset(int'($urandom_range(1, 3)), 1'($urandom));
            end else if (mode == 1) begin
                imem_ack   = 1'b1;
                imem_rdata = $urandom;
                retire     = 1'b0;
                @(negedge clk);
                do_reset(1, 1'b0);
            end else begin
                run_inst(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
                         1'($urandom), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 7) == 0), m_pc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
